// File: rtl/sram_bank_array_if.sv
// Read/write request bus between a load/store requester and sram_bank_array.
// Latency: none (wires only). Backpressure: *_ready driven by the memory side.
// master = requester, slave = memory.
interface sram_bank_array_if #(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 256,
    parameter int DATA_WIDTH = 64
);
    localparam int ADDR_BITS = $clog2(NUM_BANKS * BANK_DEPTH);
    localparam int STRB_W    = DATA_WIDTH / 8;

    logic                  read_valid;
    logic [ADDR_BITS-1:0]  read_address;
    logic                  read_ready;
    logic                  read_data_valid;
    logic [DATA_WIDTH-1:0] read_data;

    logic                  write_valid;
    logic [ADDR_BITS-1:0]  write_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [STRB_W-1:0]     write_strobe;
    logic                  write_ready;

    modport master (
        output read_valid, read_address,
        input  read_ready, read_data_valid, read_data,
        output write_valid, write_address, write_data, write_strobe,
        input  write_ready
    );

    modport slave (
        input  read_valid, read_address,
        output read_ready, read_data_valid, read_data,
        input  write_valid, write_address, write_data, write_strobe,
        output write_ready
    );
endinterface

// File: rtl/sram_bank_array.sv
// Low-order-interleaved banked SRAM with byte-strobed writes, read/write bypass, per-bank power FSM.
// Latency: read data 1 cycle after accept; writes land at the accepting edge.
// Backpressure: ready is low while the addressed bank is not ON. Optional SRAM_BANK_PERF_COUNTERS_EN adds counters.
module sram_bank_array #(
    parameter int NUM_BANKS   = 4,
    parameter int BANK_DEPTH  = 256,
    parameter int DATA_WIDTH  = 64,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_BANKS-1:0] bank_enable,
    sram_bank_array_if.slave     bus,
    output logic [NUM_BANKS-1:0] bank_awake,
    output logic                 active
`ifdef SRAM_BANK_PERF_COUNTERS_EN
    ,
    output logic [31:0]          perf_reads,
    output logic [31:0]          perf_writes,
    output logic [31:0]          perf_stalls
`endif
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ROW_BITS  = $clog2(BANK_DEPTH);
    localparam int ADDR_BITS = BANK_BITS + ROW_BITS;
    localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int CNT_W     = $clog2(WAKE_CYCLES + 1);

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_WAKING = 2'd1;
    localparam logic [1:0] ST_ON     = 2'd2;

    logic [SEL_W-1:0]    rd_bank, wr_bank;
    logic [ROW_BITS-1:0] rd_row, wr_row;

    generate
        if (BANK_BITS == 0) begin : g_single_bank
            assign rd_bank = '0;
            assign wr_bank = '0;
            assign rd_row  = bus.read_address;
            assign wr_row  = bus.write_address;
        end else begin : g_multi_bank
            assign rd_bank = bus.read_address[SEL_W-1:0];
            assign wr_bank = bus.write_address[SEL_W-1:0];
            assign rd_row  = bus.read_address[ADDR_BITS-1:BANK_BITS];
            assign wr_row  = bus.write_address[ADDR_BITS-1:BANK_BITS];
        end
    endgenerate

    logic rd_fire, wr_fire, same_addr;
    logic [DATA_WIDTH-1:0] rd_word [NUM_BANKS];
    logic [DATA_WIDTH-1:0] merged_d;

    assign bus.read_ready  = bank_awake[rd_bank];
    assign bus.write_ready = bank_awake[wr_bank];
    assign rd_fire         = bus.read_valid  && bus.read_ready;
    assign wr_fire         = bus.write_valid && bus.write_ready;
    assign same_addr       = wr_fire && (bus.read_address == bus.write_address);
    assign active          = rd_fire || wr_fire;

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [1:0]            state_q, state_d;
            logic [CNT_W-1:0]      cnt_q, cnt_d;
            logic                  awake_q;
            logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];

            // Dropping the enable wins over every other transition.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                if (!bank_enable[b]) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    case (state_q)
                        ST_OFF: begin
                            state_d = ST_WAKING;
                            cnt_d   = '0;
                        end
                        ST_WAKING: begin
                            if (cnt_q == CNT_W'(WAKE_CYCLES - 1)) begin
                                state_d = ST_ON;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        ST_ON:   state_d = ST_ON;
                        default: state_d = ST_OFF;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q <= ST_OFF;
                    cnt_q   <= '0;
                    awake_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    awake_q <= (state_d == ST_ON);
                end
            end

            assign bank_awake[b] = awake_q;

            // Storage is not reset: contents survive both power-down and reset.
            always_ff @(posedge clk) begin
                if (wr_fire && (wr_bank == SEL_W'(b))) begin
                    for (int i = 0; i < STRB_W; i++) begin
                        if (bus.write_strobe[i]) begin
                            mem[wr_row][8*i +: 8] <= bus.write_data[8*i +: 8];
                        end
                    end
                end
            end

            assign rd_word[b] = mem[rd_row];
        end
    endgenerate

    // Same-address write in the accepting cycle is forwarded byte by byte.
    always_comb begin
        merged_d = rd_word[rd_bank];
        for (int i = 0; i < STRB_W; i++) begin
            if (same_addr && bus.write_strobe[i]) begin
                merged_d[8*i +: 8] = bus.write_data[8*i +: 8];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvld_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            rvld_q  <= 1'b0;
        end else begin
            rvld_q <= rd_fire;
            if (rd_fire) begin
                rdata_q <= merged_d;
            end
        end
    end

    assign bus.read_data       = rdata_q;
    assign bus.read_data_valid = rvld_q;

`ifdef SRAM_BANK_PERF_COUNTERS_EN
    logic [31:0] reads_q, writes_q, stalls_q;
    logic        stall;

    assign stall = (bus.read_valid && !bus.read_ready) || (bus.write_valid && !bus.write_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reads_q  <= '0;
            writes_q <= '0;
            stalls_q <= '0;
        end else begin
            if (rd_fire && (reads_q != '1))  reads_q  <= reads_q + 32'd1;
            if (wr_fire && (writes_q != '1)) writes_q <= writes_q + 32'd1;
            if (stall && (stalls_q != '1))   stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_reads  = reads_q;
    assign perf_writes = writes_q;
    assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_sram_bank_array.sv
// Directed bench for sram_bank_array: wake, write/read, strobe+bypass, power drop, async reset, counters.
module tb_sram_bank_array;
    localparam int NB = 4;
    localparam int BD = 256;
    localparam int DW = 64;
    localparam int WK = 4;

    logic          clk;
    logic          reset;
    logic [NB-1:0] bank_enable;
    logic [NB-1:0] bank_awake;
    logic          active;
`ifdef SRAM_BANK_PERF_COUNTERS_EN
    logic [31:0]   perf_reads, perf_writes, perf_stalls;
`endif

    int tests = 0;
    int fails = 0;

    sram_bank_array_if #(.NUM_BANKS(NB), .BANK_DEPTH(BD), .DATA_WIDTH(DW)) bus ();

    sram_bank_array #(
        .NUM_BANKS(NB), .BANK_DEPTH(BD), .DATA_WIDTH(DW), .WAKE_CYCLES(WK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bank_enable(bank_enable),
        .bus(bus),
        .bank_awake(bank_awake),
        .active(active)
`ifdef SRAM_BANK_PERF_COUNTERS_EN
        ,
        .perf_reads(perf_reads),
        .perf_writes(perf_writes),
        .perf_stalls(perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_bus();
        bus.read_valid    = 1'b0;
        bus.read_address  = '0;
        bus.write_valid   = 1'b0;
        bus.write_address = '0;
        bus.write_data    = '0;
        bus.write_strobe  = '0;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        bank_enable = '0;
        idle_bus();
        repeat (3) @(negedge clk);
        tests++; if (bank_awake !== 4'b0000) begin fails++; $display("FAIL reset_awake: got %b want 0000", bank_awake); end
        tests++; if (bus.read_data_valid !== 1'b0) begin fails++; $display("FAIL reset_rvld: got %b want 0", bus.read_data_valid); end
        tests++; if (bus.read_data !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", bus.read_data); end
        tests++; if (bus.read_ready !== 1'b0 || bus.write_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready: got r=%b w=%b want 0 0", bus.read_ready, bus.write_ready);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wake();
        bank_enable      = 4'b0001;
        bus.read_valid   = 1'b1;
        bus.read_address = 10'd0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            tests++; if (bank_awake !== ((k >= 5) ? 4'b0001 : 4'b0000)) begin
                fails++; $display("FAIL wake_awake_%0d: got %b want %b", k, bank_awake, (k >= 5) ? 4'b0001 : 4'b0000);
            end
            tests++; if (bus.read_ready !== (k >= 5)) begin
                fails++; $display("FAIL wake_ready_%0d: got %b want %b", k, bus.read_ready, (k >= 5));
            end
        end
        bus.read_address = 10'd1;
        #1;
        tests++; if (bus.read_ready !== 1'b0) begin fails++; $display("FAIL wake_bank1_stall: got %b want 0", bus.read_ready); end
        @(negedge clk);
        tests++; if (bus.read_data_valid !== 1'b0) begin fails++; $display("FAIL wake_bank1_rvld: got %b want 0", bus.read_data_valid); end
        bus.read_valid = 1'b0;
        bank_enable    = 4'b1111;
        repeat (6) @(negedge clk);
        tests++; if (bank_awake !== 4'b1111) begin fails++; $display("FAIL wake_all: got %b want 1111", bank_awake); end
        // Clear the rows used below so their contents are known.
        for (int a = 0; a < 8; a++) begin
            bus.write_valid   = 1'b1;
            bus.write_address = 10'(a);
            bus.write_data    = '0;
            bus.write_strobe  = 8'hFF;
            @(negedge clk);
        end
        idle_bus();
    endtask

    task automatic test_write_read();
        bus.write_valid   = 1'b1;
        bus.write_address = 10'd5;
        bus.write_data    = 64'h1122334455667788;
        bus.write_strobe  = 8'hFF;
        #1;
        tests++; if (bus.write_ready !== 1'b1 || active !== 1'b1) begin
            fails++; $display("FAIL wr_handshake: got ready=%b active=%b want 1 1", bus.write_ready, active);
        end
        @(negedge clk);
        bus.write_valid  = 1'b0;
        bus.read_valid   = 1'b1;
        bus.read_address = 10'd5;
        @(negedge clk);
        tests++; if (bus.read_data_valid !== 1'b1 || bus.read_data !== 64'h1122334455667788) begin
            fails++; $display("FAIL rd_addr5: got vld=%b %h want 1 1122334455667788", bus.read_data_valid, bus.read_data);
        end
        bus.read_address = 10'd6;
        @(negedge clk);
        tests++; if (bus.read_data_valid !== 1'b1 || bus.read_data !== 64'h0) begin
            fails++; $display("FAIL rd_addr6: got vld=%b %h want 1 0", bus.read_data_valid, bus.read_data);
        end
        bus.read_valid = 1'b0;
        #1;
        tests++; if (active !== 1'b0) begin fails++; $display("FAIL idle_active: got %b want 0", active); end
        @(negedge clk);
        tests++; if (bus.read_data_valid !== 1'b0) begin fails++; $display("FAIL rvld_drop: got %b want 0", bus.read_data_valid); end
    endtask

    task automatic test_bypass();
        bus.write_valid   = 1'b1;
        bus.write_address = 10'd5;
        bus.write_data    = 64'hAAAAAAAAAAAAAAAA;
        bus.write_strobe  = 8'h0F;
        bus.read_valid    = 1'b1;
        bus.read_address  = 10'd5;
        @(negedge clk);
        tests++; if (bus.read_data !== 64'h11223344AAAAAAAA) begin
            fails++; $display("FAIL bypass_merge: got %h want 11223344aaaaaaaa", bus.read_data);
        end
        // Zero strobe handshakes but must not modify the row.
        bus.write_data   = 64'hFFFFFFFFFFFFFFFF;
        bus.write_strobe = 8'h00;
        @(negedge clk);
        tests++; if (bus.read_data !== 64'h11223344AAAAAAAA) begin
            fails++; $display("FAIL bypass_stored: got %h want 11223344aaaaaaaa", bus.read_data);
        end
        // Different rows of bank 1 in the same cycle: no interference.
        bus.write_address = 10'd1;
        bus.write_data    = 64'hDEADBEEFCAFEF00D;
        bus.write_strobe  = 8'hFF;
        @(negedge clk);
        tests++; if (bus.read_data !== 64'h11223344AAAAAAAA) begin
            fails++; $display("FAIL strobe0_and_concurrent: got %h want 11223344aaaaaaaa", bus.read_data);
        end
        bus.write_valid  = 1'b0;
        bus.read_address = 10'd1;
        @(negedge clk);
        tests++; if (bus.read_data !== 64'hDEADBEEFCAFEF00D) begin
            fails++; $display("FAIL concurrent_write: got %h want deadbeefcafef00d", bus.read_data);
        end
        bus.read_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_power_drop();
        bus.read_valid   = 1'b1;
        bus.read_address = 10'd1;
        bank_enable      = 4'b1101;
        @(negedge clk);
        tests++; if (bank_awake !== 4'b1101 || bus.read_ready !== 1'b0) begin
            fails++; $display("FAIL drop_awake: got awake=%b ready=%b want 1101 0", bank_awake, bus.read_ready);
        end
        tests++; if (bus.read_data_valid !== 1'b1) begin fails++; $display("FAIL drop_last_read: got %b want 1", bus.read_data_valid); end
        @(negedge clk);
        tests++; if (bus.read_ready !== 1'b0 || bus.read_data_valid !== 1'b0) begin
            fails++; $display("FAIL drop_stall: got ready=%b vld=%b want 0 0", bus.read_ready, bus.read_data_valid);
        end
        bank_enable = 4'b1111;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            tests++; if (bank_awake[1] !== (k >= 5) || bus.read_data_valid !== 1'b0) begin
                fails++; $display("FAIL rewake_%0d: got awake=%b vld=%b want %b 0", k, bank_awake[1], bus.read_data_valid, (k >= 5));
            end
        end
        @(negedge clk);
        tests++; if (bus.read_data_valid !== 1'b1 || bus.read_data !== 64'hDEADBEEFCAFEF00D) begin
            fails++; $display("FAIL rewake_data: got vld=%b %h want 1 deadbeefcafef00d", bus.read_data_valid, bus.read_data);
        end
        bus.read_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bus.read_valid   = 1'b1;
        bus.read_address = 10'd5;
        @(posedge clk);
        #1;
        tests++; if (bus.read_data_valid !== 1'b1) begin fails++; $display("FAIL areset_inflight: got %b want 1", bus.read_data_valid); end
        #1;
        reset = 1'b0;
        #1;
        tests++; if (bus.read_data_valid !== 1'b0 || bus.read_data !== 64'h0 || bank_awake !== 4'b0000) begin
            fails++; $display("FAIL areset_now: got vld=%b %h awake=%b want 0 0 0000", bus.read_data_valid, bus.read_data, bank_awake);
        end
        tests++; if (bus.read_ready !== 1'b0) begin fails++; $display("FAIL areset_ready: got %b want 0", bus.read_ready); end
        @(negedge clk);
        idle_bus();
        bank_enable = 4'b0001;
        reset       = 1'b1;
        @(negedge clk);
        tests++; if (bus.read_data_valid !== 1'b0 || bank_awake !== 4'b0000) begin
            fails++; $display("FAIL areset_release: got vld=%b awake=%b want 0 0000", bus.read_data_valid, bank_awake);
        end
    endtask

    task automatic test_perf();
        repeat (5) @(negedge clk);
        tests++; if (bank_awake !== 4'b0001) begin fails++; $display("FAIL perf_wake: got %b want 0001", bank_awake); end
        // Accepted traffic: reads 0,4,8 and writes 4,0, all bank 0.
        bus.read_valid = 1'b1; bus.read_address = 10'd0;
        bus.write_valid = 1'b1; bus.write_address = 10'd4; bus.write_data = 64'h5; bus.write_strobe = 8'hFF;
        @(negedge clk);
        bus.write_valid = 1'b0; bus.read_address = 10'd4;
        @(negedge clk);
        bus.write_valid = 1'b1; bus.write_address = 10'd0; bus.read_address = 10'd8;
        #1;
        tests++; if (active !== 1'b1) begin fails++; $display("FAIL perf_active: got %b want 1", active); end
        @(negedge clk);
        // Three read-only stalls, then one cycle with both sides stalled.
        bus.write_valid = 1'b0; bus.read_address = 10'd1;
        repeat (3) @(negedge clk);
        bus.write_valid = 1'b1; bus.write_address = 10'd2;
        #1;
        tests++; if (active !== 1'b0) begin fails++; $display("FAIL perf_stall_active: got %b want 0", active); end
        @(negedge clk);
        idle_bus();
        @(negedge clk);
`ifdef SRAM_BANK_PERF_COUNTERS_EN
        tests++; if (perf_reads !== 32'd3) begin fails++; $display("FAIL perf_reads: got %0d want 3", perf_reads); end
        tests++; if (perf_writes !== 32'd2) begin fails++; $display("FAIL perf_writes: got %0d want 2", perf_writes); end
        tests++; if (perf_stalls !== 32'd4) begin fails++; $display("FAIL perf_stalls: got %0d want 4", perf_stalls); end
`endif
    endtask

    initial begin
        test_reset();
        test_wake();
        test_write_read();
        test_bypass();
        test_power_drop();
        test_async_reset();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
